// File: rtl/pipe_pkg.sv
// Shared pipeline types: EX control bundle, ALU opcodes, NOP control, XZR.
// Imported by every pipeline-stage module.
package pipe_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_ORR  = 3'd3,
    ALU_EOR  = 3'd4,
    ALU_LSL  = 3'd5,
    ALU_LSR  = 3'd6,
    ALU_PASS = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic    alu_src;
    alu_op_e alu_op;
    logic    mem_rd;
    logic    mem_wr;
    logic    reg_wr;
    logic    set_flags;
  } ctrl_t;

  localparam ctrl_t      CTRL_NOP = '0;
  localparam logic [4:0] XZR      = 5'd31;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard equation between the EX slot and the decode slot.
// Purely combinational; shared by later pipeline variants.
module load_use_detect
  import pipe_pkg::*;
#(
  parameter int REG_BITS = 5
) (
  input  logic                ex_valid,
  input  logic                ex_mem_rd,
  input  logic                ex_reg_wr,
  input  logic [REG_BITS-1:0] ex_rd,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rn,
  input  logic [REG_BITS-1:0] id_rm,
  input  logic                id_uses_rm,
  output logic                hazard
);

  logic ex_is_load;
  logic rn_hit;
  logic rm_hit;

  always_comb begin
    ex_is_load = ex_valid & ex_mem_rd & ex_reg_wr
               & (ex_rd != REG_BITS'(XZR));
    rn_hit     = (id_rn == ex_rd);
    rm_hit     = id_uses_rm & (id_rm == ex_rd);
    hazard     = ex_is_load & id_valid & (rn_hit | rm_hit);
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble, stall and flush.
// IDEX_PERF_CNT_EN adds saturating bubble/stall counters.
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [WIDTH-1:0]    id_da,
  input  logic [WIDTH-1:0]    id_db,
  input  logic [WIDTH-1:0]    id_imm,
  input  ctrl_t               id_ctrl,
  input  logic [REG_BITS-1:0] id_rn,
  input  logic [REG_BITS-1:0] id_rm,
  input  logic                id_uses_rm,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                stall,
  input  logic                flush,
  output logic                ex_valid,
  output logic [WIDTH-1:0]    ex_da,
  output logic [WIDTH-1:0]    ex_db,
  output logic [WIDTH-1:0]    ex_imm,
  output ctrl_t               ex_ctrl,
  output logic [REG_BITS-1:0] ex_rn,
  output logic [REG_BITS-1:0] ex_rm,
  output logic [REG_BITS-1:0] ex_rd,
  output logic                hazard_stall
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [31:0]         bubble_cnt,
  output logic [31:0]         stall_cnt
`endif
);

  logic                valid_q, valid_d;
  logic [WIDTH-1:0]    da_q, da_d;
  logic [WIDTH-1:0]    db_q, db_d;
  logic [WIDTH-1:0]    imm_q, imm_d;
  ctrl_t               ctrl_q, ctrl_d;
  logic [REG_BITS-1:0] rn_q, rn_d;
  logic [REG_BITS-1:0] rm_q, rm_d;
  logic [REG_BITS-1:0] rd_q, rd_d;

  logic hazard;
  logic do_bubble;
  logic do_load;
  logic hz_bubble;

  load_use_detect #(
    .REG_BITS (REG_BITS)
  ) u_lud (
    .ex_valid   (valid_q),
    .ex_mem_rd  (ctrl_q.mem_rd),
    .ex_reg_wr  (ctrl_q.reg_wr),
    .ex_rd      (rd_q),
    .id_valid   (id_valid),
    .id_rn      (id_rn),
    .id_rm      (id_rm),
    .id_uses_rm (id_uses_rm),
    .hazard     (hazard)
  );

  // flush beats stall; stall beats the hazard bubble
  always_comb begin
    hz_bubble = ~flush & ~stall & hazard;
    do_bubble = flush | hz_bubble;
    do_load   = ~flush & ~stall & ~hazard;
  end

  always_comb begin
    valid_d = valid_q;
    da_d    = da_q;
    db_d    = db_q;
    imm_d   = imm_q;
    ctrl_d  = ctrl_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    rd_d    = rd_q;
    if (do_bubble) begin
      valid_d = 1'b0;
      da_d    = '0;
      db_d    = '0;
      imm_d   = '0;
      ctrl_d  = CTRL_NOP;
      rn_d    = '0;
      rm_d    = '0;
      rd_d    = '0;
    end else if (do_load) begin
      valid_d = id_valid;
      da_d    = id_da;
      db_d    = id_db;
      imm_d   = id_imm;
      ctrl_d  = id_valid ? id_ctrl : CTRL_NOP;
      rn_d    = id_rn;
      rm_d    = id_rm;
      rd_d    = id_rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      da_q    <= '0;
      db_q    <= '0;
      imm_q   <= '0;
      ctrl_q  <= CTRL_NOP;
      rn_q    <= '0;
      rm_q    <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      da_q    <= da_d;
      db_q    <= db_d;
      imm_q   <= imm_d;
      ctrl_q  <= ctrl_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      rd_q    <= rd_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_da        = da_q;
  assign ex_db        = db_q;
  assign ex_imm       = imm_q;
  assign ex_ctrl      = ctrl_q;
  assign ex_rn        = rn_q;
  assign ex_rm        = rm_q;
  assign ex_rd        = rd_q;
  assign hazard_stall = hazard;

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // counters saturate and ignore flush
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (hz_bubble && bubble_cnt_q != '1)
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    if (stall && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: vector table with an EX scoreboard queue,
// plus reset, saturation and mid-hazard reset sequences.
module tb_id_ex_pipe_reg;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [63:0] id_da, id_db, id_imm;
  ctrl_t       id_ctrl;
  logic [4:0]  id_rn, id_rm, id_rd;
  logic        id_uses_rm;
  logic        stall, flush;
  logic        ex_valid;
  logic [63:0] ex_da, ex_db, ex_imm;
  ctrl_t       ex_ctrl;
  logic [4:0]  ex_rn, ex_rm, ex_rd;
  logic        hazard_stall;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0] bubble_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.WIDTH(64), .REG_BITS(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_da        (id_da),
    .id_db        (id_db),
    .id_imm       (id_imm),
    .id_ctrl      (id_ctrl),
    .id_rn        (id_rn),
    .id_rm        (id_rm),
    .id_uses_rm   (id_uses_rm),
    .id_rd        (id_rd),
    .stall        (stall),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .ex_da        (ex_da),
    .ex_db        (ex_db),
    .ex_imm       (ex_imm),
    .ex_ctrl      (ex_ctrl),
    .ex_rn        (ex_rn),
    .ex_rm        (ex_rm),
    .ex_rd        (ex_rd),
    .hazard_stall (hazard_stall)
`ifdef IDEX_PERF_CNT_EN
    ,
    .bubble_cnt   (bubble_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  typedef struct packed {
    logic        valid;
    logic [63:0] da;
    logic [63:0] db;
    logic [63:0] imm;
    ctrl_t       ctrl;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [4:0]  rd;
  } ex_t;

  typedef enum {K_LOAD, K_HOLD, K_ZERO} kind_e;

  typedef struct {
    logic        v;
    logic [63:0] da, db, imm;
    ctrl_t       c;
    logic [4:0]  rn, rm, rd;
    logic        um, st, fl;
    logic        haz;
    kind_e       k;
  } vec_t;

  vec_t tbl[$];
  ex_t  sb[$];
  ex_t  last;
  ex_t  exp_r;
  int   n_pass = 0;
  int   n_total = 0;

  function automatic ctrl_t mk(logic src, alu_op_e op, logic mr,
                               logic mw, logic rw, logic sf);
    ctrl_t c;
    c.alu_src   = src;
    c.alu_op    = op;
    c.mem_rd    = mr;
    c.mem_wr    = mw;
    c.reg_wr    = rw;
    c.set_flags = sf;
    return c;
  endfunction

  function automatic ex_t got_ex();
    return {ex_valid, ex_da, ex_db, ex_imm, ex_ctrl, ex_rn, ex_rm, ex_rd};
  endfunction

  task automatic chk(input string nm, input logic [255:0] got,
                     input logic [255:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    else
      n_pass++;
  endtask

  task automatic add(input logic v, input logic [63:0] da,
                     input logic [63:0] db, input logic [63:0] imm,
                     input ctrl_t c, input logic [4:0] rn,
                     input logic [4:0] rm, input logic [4:0] rd,
                     input logic um, input logic st, input logic fl,
                     input logic haz, input kind_e k);
    vec_t x;
    x.v = v; x.da = da; x.db = db; x.imm = imm; x.c = c;
    x.rn = rn; x.rm = rm; x.rd = rd; x.um = um;
    x.st = st; x.fl = fl; x.haz = haz; x.k = k;
    tbl.push_back(x);
  endtask

  task automatic drive(input vec_t x);
    id_valid = x.v; id_da = x.da; id_db = x.db; id_imm = x.imm;
    id_ctrl = x.c; id_rn = x.rn; id_rm = x.rm; id_rd = x.rd;
    id_uses_rm = x.um; stall = x.st; flush = x.fl;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ctrl_t ld, ad, ai;
    ld = mk(1'b1, ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0);
    ad = mk(1'b0, ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
    ai = mk(1'b1, ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b0);

    // v  da      db     imm    c   rn  rm  rd  um st fl haz kind
    add(1, 'h100,  0,     8,     ld, 1,  0,  3,  0, 0, 0, 0, K_LOAD);
    add(1, 'hA,    'hB,   0,     ad, 3,  4,  5,  1, 0, 0, 1, K_ZERO);
    add(1, 'hA,    'hB,   0,     ad, 3,  4,  5,  1, 0, 0, 0, K_LOAD);
    add(1, 'h200,  0,     'h10,  ld, 2,  0,  31, 0, 0, 0, 0, K_LOAD);
    add(1, 'hC,    'hD,   0,     ad, 31, 31, 6,  1, 0, 0, 0, K_LOAD);
    add(1, 'h300,  0,     'h18,  ld, 1,  0,  7,  0, 0, 0, 0, K_LOAD);
    add(1, 'hE,    'hF,   4,     ai, 2,  7,  8,  0, 0, 0, 0, K_LOAD);
    add(1, 'h400,  0,     'h20,  ld, 1,  0,  9,  0, 0, 0, 0, K_LOAD);
    add(1, 1,      2,     0,     ad, 1,  9,  11, 1, 0, 0, 1, K_ZERO);
    add(1, 1,      'h99,  'h10,  ai, 2,  0,  10, 0, 0, 0, 0, K_LOAD);
    add(0, 'h55,   'h66,  'h77,  ld, 3,  3,  3,  1, 0, 0, 0, K_LOAD);
    add(1, 'h500,  0,     0,     ld, 1,  0,  12, 0, 0, 0, 0, K_LOAD);
    add(0, 1,      1,     1,     ad, 12, 12, 13, 1, 0, 0, 0, K_LOAD);
    add(1, 'hAAAA, 0,     0,     ld, 1,  0,  4,  0, 0, 0, 0, K_LOAD);
    add(1, 1,      0,     0,     ad, 4,  0,  5,  0, 1, 0, 1, K_HOLD);
    add(1, 2,      0,     0,     ad, 4,  0,  5,  0, 1, 0, 1, K_HOLD);
    add(1, 3,      0,     0,     ad, 4,  0,  5,  0, 1, 0, 1, K_HOLD);
    add(1, 4,      0,     0,     ad, 4,  0,  5,  0, 1, 0, 1, K_HOLD);
    add(1, 5,      0,     0,     ad, 4,  0,  5,  0, 1, 1, 1, K_ZERO);
    add(1, 6,      0,     0,     ad, 4,  0,  5,  0, 0, 0, 0, K_LOAD);
    add(1, 'h700,  0,     0,     ld, 1,  0,  4,  0, 0, 0, 0, K_LOAD);
    add(1, 7,      0,     0,     ad, 4,  0,  5,  0, 0, 1, 1, K_ZERO);
    add(1, 8,      0,     0,     ad, 4,  0,  5,  0, 0, 0, 0, K_LOAD);

    // reset with all-ones inputs held
    reset = 1'b0;
    id_valid = 1'b1; id_da = '1; id_db = '1; id_imm = '1;
    id_ctrl = '1; id_rn = '1; id_rm = '1; id_rd = '1;
    id_uses_rm = 1'b1; stall = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ex", 256'(got_ex()), 256'(ex_t'('0)));
    chk("rst_haz", 256'(hazard_stall), 256'(0));
    reset = 1'b1;
    last = '1;
    @(posedge clk); #1;
    chk("first_load", 256'(got_ex()), 256'(last));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("haz_v%0d", i), 256'(hazard_stall), 256'(tbl[i].haz));
      case (tbl[i].k)
        K_LOAD: begin
          exp_r.valid = tbl[i].v;
          exp_r.da    = tbl[i].da;
          exp_r.db    = tbl[i].db;
          exp_r.imm   = tbl[i].imm;
          exp_r.ctrl  = tbl[i].v ? tbl[i].c : CTRL_NOP;
          exp_r.rn    = tbl[i].rn;
          exp_r.rm    = tbl[i].rm;
          exp_r.rd    = tbl[i].rd;
        end
        K_HOLD:  exp_r = last;
        default: exp_r = '0;
      endcase
      sb.push_back(exp_r);
      last = exp_r;
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        chk($sformatf("sb_empty_v%0d", i), 256'(1), 256'(0));
      end else begin
        exp_r = sb.pop_front();
        chk($sformatf("ex_v%0d", i), 256'(got_ex()), 256'(exp_r));
      end
    end

    // immediate path: alu_src selects ex_imm
    @(negedge clk);
    id_valid = 1'b1; id_ctrl = ai; id_imm = 64'h10; id_db = 64'h99;
    id_rn = 5'd1; id_rm = 5'd2; id_rd = 5'd3; id_uses_rm = 1'b0;
    stall = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    chk("alu_src", 256'(ex_ctrl.alu_src), 256'(1));
    chk("ex_imm", 256'(ex_imm), 256'(64'h10));

`ifdef IDEX_PERF_CNT_EN
    chk("bubble_cnt", 256'(bubble_cnt), 256'(2));
    chk("stall_cnt", 256'(stall_cnt), 256'(5));
    @(negedge clk);
    force dut.bubble_cnt_q = 32'hFFFF_FFFF;
    force dut.stall_cnt_q  = 32'hFFFF_FFFF;
    #1;
    release dut.bubble_cnt_q;
    release dut.stall_cnt_q;
    id_ctrl = ld; id_rd = 5'd3;
    @(negedge clk);
    id_ctrl = ad; id_rn = 5'd3; id_rd = 5'd5;
    @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    stall = 1'b0;
    chk("bubble_sat", 256'(bubble_cnt), 256'(32'hFFFF_FFFF));
    chk("stall_sat", 256'(stall_cnt), 256'(32'hFFFF_FFFF));
`endif

    // reset asserted while a hazard is active
    @(negedge clk);
    id_valid = 1'b1; id_ctrl = ld; id_rn = 5'd1; id_rd = 5'd3;
    id_uses_rm = 1'b0; stall = 1'b0; flush = 1'b0;
    @(negedge clk);
    id_ctrl = ad; id_rn = 5'd3; id_rm = 5'd4; id_rd = 5'd5;
    id_uses_rm = 1'b1; id_da = 64'h1234;
    #1;
    chk("mid_haz", 256'(hazard_stall), 256'(1));
    reset = 1'b0;
    #1;
    chk("mid_rst_ex", 256'(got_ex()), 256'(ex_t'('0)));
    chk("mid_rst_haz", 256'(hazard_stall), 256'(0));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", 256'(ex_valid), 256'(1));
    chk("post_rst_da", 256'(ex_da), 256'(64'h1234));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
